// File: rtl/proj_pkg.sv
// Shared project package for the MinHash signature path.
// Holds the hasher/sorter/extender interface widths, the bottom-K sorter
// defaults, the sorter state encoding and the packed (signature, index) pair.
package proj_pkg;

  localparam int HASHER_SORTER_SIGNATURE       = 32;
  localparam int INDICE_LEN                    = 9;
  localparam int SORTER_EXTENDER_INDICES_COUNT = 32;

  localparam int SORTER_DEPTH     = SORTER_EXTENDER_INDICES_COUNT;
  localparam int SORTER_COUNT_LEN = $clog2(SORTER_DEPTH + 1);
  localparam bit SORTER_DEDUP     = 1'b1;

  typedef enum logic {
    SORTER_FILL,
    SORTER_DRAIN
  } sorter_state_e;

  // One stored sorter entry at the default widths.
  typedef struct packed {
    logic [HASHER_SORTER_SIGNATURE-1:0] sig;
    logic [INDICE_LEN-1:0]              idx;
  } signature_index_pack;

endpackage

// File: rtl/minhash_topk_sorter_cell.sv
// sorter_cell: one slot of the bottom-K insertion chain.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clr_i                 invalidate the slot (end of frame)
//   ins_i                 an insertion happens this cycle somewhere in the chain
//   new_sig_i/new_idx_i   incoming pair
//   up_*_i                entry and greater-than flag of the upstream slot
//   valid_o/sig_o/idx_o   stored entry
//   gt_o                  slot is empty or holds a signature > new_sig_i
//   eq_o                  slot is valid and holds a signature == new_sig_i
module sorter_cell
  import proj_pkg::*;
#(
  parameter int SIG_W = HASHER_SORTER_SIGNATURE,
  parameter int IDX_W = INDICE_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             ins_i,
  input  logic [SIG_W-1:0] new_sig_i,
  input  logic [IDX_W-1:0] new_idx_i,
  input  logic             up_valid_i,
  input  logic [SIG_W-1:0] up_sig_i,
  input  logic [IDX_W-1:0] up_idx_i,
  input  logic             up_gt_i,
  output logic             valid_o,
  output logic [SIG_W-1:0] sig_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             gt_o,
  output logic             eq_o
);

  logic             valid_q, valid_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Strictly-greater keeps equal signatures ahead of the newcomer (stable).
  assign gt_o = !valid_q || (sig_q > new_sig_i);
  assign eq_o = valid_q && (sig_q == new_sig_i);

  always_comb begin
    valid_d = valid_q;
    sig_d   = sig_q;
    idx_d   = idx_q;
    if (clr_i) begin
      valid_d = 1'b0;
      sig_d   = '0;
      idx_d   = '0;
    end else if (ins_i && gt_o) begin
      if (up_gt_i) begin
        // Insertion point is above us: take the upstream entry.
        valid_d = up_valid_i;
        sig_d   = up_sig_i;
        idx_d   = up_idx_i;
      end else begin
        // We are the first greater slot: the newcomer lands here.
        valid_d = 1'b1;
        sig_d   = new_sig_i;
        idx_d   = new_idx_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sig_q   <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sig_q   <= sig_d;
      idx_q   <= idx_d;
    end
  end

  assign valid_o = valid_q;
  assign sig_o   = sig_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/minhash_topk_sorter.sv
// minhash_topk_sorter: streaming bottom-K sorter between hasher and extender.
// Keeps the DEPTH smallest signatures of a fragment in ascending order, then
// drains them with their FM indices once the in_last beat has been absorbed.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             input handshake (ready only while filling)
//   in_sig/in_idx/in_last         incoming pair, last beat of fragment
//   out_valid/out_ready           drain handshake
//   out_sig/out_idx/out_pos       drained entry and its rank
//   out_last                      final retained entry
//   count                         number of valid stored entries
module minhash_topk_sorter
  import proj_pkg::*;
#(
  parameter int SIG_W = HASHER_SORTER_SIGNATURE,
  parameter int IDX_W = INDICE_LEN,
  parameter int DEPTH = SORTER_DEPTH,
  parameter bit DEDUP = SORTER_DEDUP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIG_W-1:0]           in_sig,
  input  logic [IDX_W-1:0]           in_idx,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIG_W-1:0]           out_sig,
  output logic [IDX_W-1:0]           out_idx,
  output logic [$clog2(DEPTH)-1:0]   out_pos,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  sorter_state_e    state_q, state_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             clear_all;

  logic [DEPTH-1:0] cell_valid, cell_gt, cell_eq;
  logic [SIG_W-1:0] cell_sig [DEPTH];
  logic [IDX_W-1:0] cell_idx [DEPTH];
  logic [DEPTH-1:0] up_valid, up_gt;
  logic [SIG_W-1:0] up_sig [DEPTH];
  logic [IDX_W-1:0] up_idx [DEPTH];

  logic accept, dup_hit, insert;

  assign accept  = in_valid && (state_q == SORTER_FILL);
  assign dup_hit = DEDUP && (|cell_eq);
  // The chain is sorted with empties at the tail, so the last slot's flag
  // says whether any insertion point exists at all.
  assign insert  = accept && cell_gt[DEPTH-1] && !dup_hit;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    if (gi == 0) begin : g_head
      assign up_valid[gi] = 1'b0;
      assign up_gt[gi]    = 1'b0;
      assign up_sig[gi]   = '0;
      assign up_idx[gi]   = '0;
    end else begin : g_link
      assign up_valid[gi] = cell_valid[gi-1];
      assign up_gt[gi]    = cell_gt[gi-1];
      assign up_sig[gi]   = cell_sig[gi-1];
      assign up_idx[gi]   = cell_idx[gi-1];
    end

    sorter_cell #(
      .SIG_W(SIG_W),
      .IDX_W(IDX_W)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clear_all),
      .ins_i     (insert),
      .new_sig_i (in_sig),
      .new_idx_i (in_idx),
      .up_valid_i(up_valid[gi]),
      .up_sig_i  (up_sig[gi]),
      .up_idx_i  (up_idx[gi]),
      .up_gt_i   (up_gt[gi]),
      .valid_o   (cell_valid[gi]),
      .sig_o     (cell_sig[gi]),
      .idx_o     (cell_idx[gi]),
      .gt_o      (cell_gt[gi]),
      .eq_o      (cell_eq[gi])
    );
  end

  always_comb begin
    state_d   = state_q;
    rp_d      = rp_q;
    count_d   = count_q;
    clear_all = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_pos   = '0;
    out_sig   = '0;
    out_idx   = '0;
    case (state_q)
      SORTER_FILL: begin
        in_ready = 1'b1;
        if (insert && (count_q != FULL_C)) count_d = count_q + CNT_W'(1);
        if (accept && in_last) begin
          state_d = SORTER_DRAIN;
          rp_d    = '0;
        end
      end
      SORTER_DRAIN: begin
        out_valid = (CNT_W'(rp_q) < count_q);
        if (out_valid) begin
          out_sig  = cell_sig[rp_q];
          out_idx  = cell_idx[rp_q];
          out_pos  = rp_q;
          out_last = (CNT_W'(rp_q) == (count_q - CNT_W'(1)));
          if (out_ready) begin
            if (out_last) begin
              clear_all = 1'b1;
              count_d   = '0;
              rp_d      = '0;
              state_d   = SORTER_FILL;
            end else begin
              rp_d = rp_q + PTR_W'(1);
            end
          end
        end
      end
      default: state_d = SORTER_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SORTER_FILL;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_minhash_topk_sorter.sv
// Directed bench: two DEPTH=4 sorters (DEDUP=1 as "a", DEDUP=0 as "b")
// share one stimulus stream; each scenario checks its own outputs.
module tb_minhash_topk_sorter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [31:0] in_sig;
  logic [8:0]  in_idx;

  logic        a_in_ready, a_out_valid, a_out_last;
  logic [31:0] a_out_sig;
  logic [8:0]  a_out_idx;
  logic [1:0]  a_out_pos;
  logic [2:0]  a_count;

  logic        b_in_ready, b_out_valid, b_out_last;
  logic [31:0] b_out_sig;
  logic [8:0]  b_out_idx;
  logic [1:0]  b_out_pos;
  logic [2:0]  b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minhash_topk_sorter #(.SIG_W(32), .IDX_W(9), .DEPTH(4), .DEDUP(1'b1)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_sig(in_sig), .in_idx(in_idx), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_sig(a_out_sig), .out_idx(a_out_idx),
    .out_pos(a_out_pos), .out_last(a_out_last), .count(a_count)
  );

  minhash_topk_sorter #(.SIG_W(32), .IDX_W(9), .DEPTH(4), .DEDUP(1'b0)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_sig(in_sig), .in_idx(in_idx), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_sig(b_out_sig), .out_idx(b_out_idx),
    .out_pos(b_out_pos), .out_last(b_out_last), .count(b_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic send(input logic [31:0] s, input logic [8:0] i, input logic l);
    in_valid = 1'b1;
    in_sig   = s;
    in_idx   = i;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_out_sig !== 32'd0 ||
        a_out_idx !== 9'd0 || a_out_pos !== 2'd0 || a_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_a got rdy=%b v=%b last=%b sig=%0d idx=%0d pos=%0d cnt=%0d exp 1 0 0 0 0 0 0",
               a_in_ready, a_out_valid, a_out_last, a_out_sig, a_out_idx, a_out_pos, a_count);
    end
    checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_b got rdy=%b v=%b cnt=%0d exp 1 0 0", b_in_ready, b_out_valid, b_count);
    end
  endtask

  task automatic test_basic;
    logic [31:0] es [4];
    logic [8:0]  ei [4];
    es = '{32'd10, 32'd20, 32'd30, 32'd40};
    ei = '{9'd1, 9'd3, 9'd4, 9'd2};
    send(32'd50, 9'd0, 1'b0);
    send(32'd10, 9'd1, 1'b0);
    send(32'd40, 9'd2, 1'b0);
    send(32'd20, 9'd3, 1'b0);
    send(32'd30, 9'd4, 1'b1);
    checks++;
    if (a_count !== 3'd4) begin
      errors++;
      $display("FAIL basic_count got %0d exp 4", a_count);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_out_sig !== es[k] || a_out_idx !== ei[k] ||
          a_out_pos !== 2'(k) || a_out_last !== (k == 3)) begin
        errors++;
        $display("FAIL basic_drain[%0d] got v=%b sig=%0d idx=%0d pos=%0d last=%b exp v=1 sig=%0d idx=%0d pos=%0d last=%b",
                 k, a_out_valid, a_out_sig, a_out_idx, a_out_pos, a_out_last, es[k], ei[k], k, (k == 3));
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_count !== 3'd0) begin
      errors++;
      $display("FAIL basic_after got rdy=%b v=%b cnt=%0d exp 1 0 0", a_in_ready, a_out_valid, a_count);
    end
  endtask

  task automatic test_two_entries;
    send(32'd7, 9'd0, 1'b0);
    send(32'd3, 9'd1, 1'b1);
    out_ready = 1'b1;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sig !== 32'd3 || a_out_idx !== 9'd1 || a_out_pos !== 2'd0 || a_out_last !== 1'b0) begin
      errors++;
      $display("FAIL two_first got v=%b sig=%0d idx=%0d pos=%0d last=%b exp 1 3 1 0 0",
               a_out_valid, a_out_sig, a_out_idx, a_out_pos, a_out_last);
    end
    @(posedge clk);
    #1;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sig !== 32'd7 || a_out_idx !== 9'd0 || a_out_pos !== 2'd1 || a_out_last !== 1'b1) begin
      errors++;
      $display("FAIL two_second got v=%b sig=%0d idx=%0d pos=%0d last=%b exp 1 7 0 1 1",
               a_out_valid, a_out_sig, a_out_idx, a_out_pos, a_out_last);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_ready_after got rdy=%b v=%b exp 1 0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_dedup;
    logic [31:0] es [3];
    logic [8:0]  ei [3];
    es = '{32'd2, 32'd5, 32'd5};
    ei = '{9'd3, 9'd1, 9'd2};
    send(32'd5, 9'd1, 1'b0);
    send(32'd5, 9'd2, 1'b0);
    send(32'd2, 9'd3, 1'b1);
    checks++;
    if (a_count !== 3'd2 || b_count !== 3'd3) begin
      errors++;
      $display("FAIL dedup_count got a=%0d b=%0d exp a=2 b=3", a_count, b_count);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_sig !== es[k] || a_out_idx !== ei[k] || a_out_last !== (k == 1)) begin
          errors++;
          $display("FAIL dedup_on[%0d] got v=%b sig=%0d idx=%0d last=%b exp v=1 sig=%0d idx=%0d last=%b",
                   k, a_out_valid, a_out_sig, a_out_idx, a_out_last, es[k], ei[k], (k == 1));
        end
      end
      checks++;
      if (b_out_valid !== 1'b1 || b_out_sig !== es[k] || b_out_idx !== ei[k] ||
          b_out_pos !== 2'(k) || b_out_last !== (k == 2)) begin
        errors++;
        $display("FAIL dedup_off[%0d] got v=%b sig=%0d idx=%0d pos=%0d last=%b exp v=1 sig=%0d idx=%0d pos=%0d last=%b",
                 k, b_out_valid, b_out_sig, b_out_idx, b_out_pos, b_out_last, es[k], ei[k], k, (k == 2));
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL dedup_after got a_rdy=%b b_rdy=%b exp 1 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_back_pressure;
    logic [31:0] es [4];
    logic [8:0]  ei [4];
    logic        pat [4];
    int          e;
    es  = '{32'd1, 32'd2, 32'd3, 32'd4};
    ei  = '{9'd1, 9'd3, 9'd2, 9'd0};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    e   = 0;
    send(32'd4, 9'd0, 1'b0);
    send(32'd1, 9'd1, 1'b0);
    send(32'd3, 9'd2, 1'b0);
    send(32'd2, 9'd3, 1'b1);
    for (int c = 0; c < 20 && e < 4; c++) begin
      out_ready = pat[c % 4];
      checks++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_sig !== es[e] ||
          a_out_idx !== ei[e] || a_out_pos !== 2'(e)) begin
        errors++;
        $display("FAIL bp_cycle[%0d] got v=%b rdy=%b sig=%0d idx=%0d pos=%0d exp v=1 rdy=0 sig=%0d idx=%0d pos=%0d",
                 c, a_out_valid, a_in_ready, a_out_sig, a_out_idx, a_out_pos, es[e], ei[e], e);
      end
      @(posedge clk);
      if (out_ready) e++;
      #1;
    end
    out_ready = 1'b0;
    checks++;
    if (e != 4 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_done got taken=%0d v=%b rdy=%b exp 4 0 1", e, a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_full_large;
    logic [31:0] es [4];
    logic [8:0]  ei [4];
    es = '{32'd0, 32'd1, 32'd2, 32'd3};
    ei = '{9'd5, 9'd0, 9'd1, 9'd2};
    send(32'd1, 9'd0, 1'b0);
    send(32'd2, 9'd1, 1'b0);
    send(32'd3, 9'd2, 1'b0);
    send(32'd4, 9'd3, 1'b0);
    send(32'd9, 9'd4, 1'b0);
    checks++;
    if (a_count !== 3'd4) begin
      errors++;
      $display("FAIL full_count got %0d exp 4", a_count);
    end
    send(32'd0, 9'd5, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_out_sig !== es[k] || a_out_idx !== ei[k] || a_out_last !== (k == 3)) begin
        errors++;
        $display("FAIL full_drain[%0d] got v=%b sig=%0d idx=%0d last=%b exp v=1 sig=%0d idx=%0d last=%b",
                 k, a_out_valid, a_out_sig, a_out_idx, a_out_last, es[k], ei[k], (k == 3));
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain;
    send(32'd6, 9'd0, 1'b0);
    send(32'd5, 9'd1, 1'b0);
    send(32'd4, 9'd2, 1'b1);
    out_ready = 1'b1;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sig !== 32'd4 || a_out_idx !== 9'd2) begin
      errors++;
      $display("FAIL rstmid_first got v=%b sig=%0d idx=%0d exp 1 4 2", a_out_valid, a_out_sig, a_out_idx);
    end
    @(posedge clk);
    #1;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sig !== 32'd5 || a_out_idx !== 9'd1) begin
      errors++;
      $display("FAIL rstmid_second got v=%b sig=%0d idx=%0d exp 1 5 1", a_out_valid, a_out_sig, a_out_idx);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_count !== 3'd0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after got v=%b cnt=%0d rdy=%b exp 0 0 1", a_out_valid, a_count, a_in_ready);
    end
    send(32'd8, 9'd7, 1'b1);
    out_ready = 1'b1;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_sig !== 32'd8 || a_out_idx !== 9'd7 || a_out_pos !== 2'd0 ||
        a_out_last !== 1'b1 || a_count !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_newframe got v=%b sig=%0d idx=%0d pos=%0d last=%b cnt=%0d exp 1 8 7 0 1 1",
               a_out_valid, a_out_sig, a_out_idx, a_out_pos, a_out_last, a_count);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_end got v=%b rdy=%b exp 0 1", a_out_valid, a_in_ready);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_sig    = '0;
    in_idx    = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_two_entries();
    test_dedup();
    test_back_pressure();
    test_full_large();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minhash_topk_sorter.md
Name: minhash_topk_sorter

Overview:
Streaming bottom-K sorter for the MinHash signature path. It sits between the hasher and the extender. It accepts one (signature, index) pair per cycle for a fragment and retains the DEPTH smallest signatures in ascending order. After the fragment's last beat it drains the retained pairs, in order, to the extender. It generalises the fixed 32-entry sorter with parametrised depth and widths, optional duplicate suppression, partial-fill drain and frame handshaking.

Parameters:
SIG_W, 32 (HASHER_SORTER_SIGNATURE), signature width in bits.
IDX_W, 9 (INDICE_LEN), FM index width in bits.
DEPTH, 32 (SORTER_EXTENDER_INDICES_COUNT), number of retained entries; must be at least 2.
DEDUP, 1, 1 = discard an input whose signature equals a stored signature; 0 = keep duplicates (stable order).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  sorter accepts input
in_sig  in  SIG_W  hashed k-mer signature
in_idx  in  IDX_W  FM index of the k-mer
in_last  in  1  final beat of the fragment
out_valid  out  1  drained entry valid
out_ready  in  1  extender accepts entry
out_sig  out  SIG_W  drained signature
out_idx  out  IDX_W  drained index
out_pos  out  $clog2(DEPTH)  rank of the entry, 0 = smallest
out_last  out  1  final retained entry of the fragment
count  out  $clog2(DEPTH+1)  number of valid stored entries

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); all state is updated on the rising edge of clk.
- Reset values: state=FILL, count=0, all entry valid bits=0, in_ready=1, out_valid=0, out_last=0, out_sig=0, out_idx=0, out_pos=0.
- Reset asserted mid-fill or mid-drain: the frame is abandoned, all entries are invalidated, and nothing more is output.
- FILL state:
  - in_ready=1 and out_valid=0.
  - A beat is accepted when in_valid && in_ready.
  - Each entry i compares in_sig against its stored signature (unsigned). The insertion point p is the first entry whose signature is strictly greater than in_sig, or the first invalid entry.
  - Entries at positions p and above shift down one place; the new pair is written at p. If count==DEPTH, the entry at DEPTH-1 is dropped and count is unchanged; otherwise count increments.
  - If count==DEPTH and in_sig >= the signature at DEPTH-1, the beat is consumed and has no effect.
  - If DEDUP=1 and in_sig equals any valid stored signature, the beat is consumed and has no effect; the first stored index wins.
  - If DEDUP=0, an equal signature is inserted after the existing equal entries, so the sort is stable.
  - The table and count update one cycle after acceptance.
  - An accepted beat with in_last=1 is processed as above, then the state moves to DRAIN on the next cycle.
- DRAIN state:
  - in_ready=0.
  - A read pointer rp starts at 0.
  - out_valid=1 while rp<count. Outputs are out_sig/out_idx of entry rp, out_pos=rp, and out_last=(rp==count-1).
  - The first out_valid is asserted in the cycle after the in_last beat is accepted.
  - rp advances on each out_valid && out_ready. Output data must stay stable while out_valid=1 and out_ready=0.
  - On the handshake with out_last=1, the next cycle clears all entries, sets count=0, state=FILL and in_ready=1.
  - count is never 0 in DRAIN, because in_last always comes with a valid beat.
- Throughput: one input per cycle in FILL, one output per cycle in DRAIN, with no stall cycles other than out_ready back-pressure.
- Width rules: comparisons are unsigned at full SIG_W width, and the index is never part of the comparison. count saturates at DEPTH.

Decomposition:
- Shared package (proj_pkg) gains:
  - SORTER_DEPTH = SORTER_EXTENDER_INDICES_COUNT
  - SORTER_COUNT_LEN = $clog2(SORTER_DEPTH+1)
  - SORTER_DEDUP default
  - enum sorter_state_e {SORTER_FILL, SORTER_DRAIN}
  - signature_index_pack is reused for stored entries at default widths.
- One sub-module, sorter_cell: it holds a valid bit, signature and index. Inputs are the incoming pair, the upstream cell's entry, and the upstream cell's "greater-than" flag. Outputs are its stored entry and its own greater-than flag. It selects hold, load-new or shift-from-upstream; the top module instantiates DEPTH cells in a chain.

Test Plan:
- DEPTH=4, DEDUP=1; inputs 50,10,40,20,30 (idx 0-4), last on 30 -> drain 10/1,20/3,30/4,40/2, out_pos 0-3, out_last on pos 3; count=4.
- DEPTH=4; inputs 7,3 (last on 3) -> drain 3 then 7; out_last on the second entry; in_ready=1 the cycle after the out_last handshake.
- DEDUP=1; inputs 5/idx1, 5/idx2, 2/idx3, last -> drain 2/3, 5/1, count=2. Same stimulus with DEDUP=0 -> 2/3, 5/1, 5/2.
- Back-pressure: drain with out_ready toggling 1,0,0,1 -> data held stable while stalled; each entry output exactly once; in_ready=0 throughout DRAIN.
- Full with large input: DEPTH=4 holding 1,2,3,4; input 9 then last 0 -> 9 discarded; drain 0,1,2,3.
- Assert rst mid-drain after 2 outputs -> next cycle out_valid=0, count=0, in_ready=1; a new frame 8 (last) drains only 8.
